// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the serial packed-BCD adder/subtractor.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  // Nine's complement of one BCD digit, kept to 4 bits so invalid digits wrap deterministically.
  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_addsub_serial_if.sv
// Request/result bundle between an operand source and the serial BCD adder/subtractor.
interface bcd_addsub_serial_if #(
  parameter int DIGITS = 4
);
  localparam int W = 4 * DIGITS;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         ready;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         err;

  modport master (
    output start, sub, a, b, c_in,
    input  ready, done, sum, c_out, err
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output ready, done, sum, c_out, err
  );

endinterface

// File: rtl/bcd_digit_cell.sv
// Single-digit BCD add with decimal correction; reused for every digit position.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] t;

  // Binary add, then add 6 when the raw sum leaves the decimal range.
  always_comb begin
    t = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (t > {1'b0, BCD_MAX}) begin
      s    = t[3:0] + BCD_ADJ;
      cout = 1'b1;
    end else begin
      s    = t[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, least-significant first.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_addsub_serial_if.slave bus
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     res_q, res_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             err_q, err_d;

  logic             ready;
  logic             last;
  logic             invalid;
  logic [3:0]       a_dig, b_dig, cell_b, cell_s;
  logic             cell_cout;

  assign last   = (cnt_q == CNT_LAST);
  assign cell_b = sub_q ? nines_comp(b_dig) : b_dig;

  bcd_digit_cell u_cell (
    .a    (a_dig),
    .b    (cell_b),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  // Select the captured operand digits addressed by the digit counter.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
  end

  // Flag any non-decimal digit in the operands being offered for capture.
  always_comb begin
    invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.a[4*i +: 4] > BCD_MAX || bus.b[4*i +: 4] > BCD_MAX) begin
        invalid = 1'b1;
      end
    end
  end

  // State register and datapath flops, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept in IDLE, walk the digits, pulse DONE once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, one digit per RUN cycle; the finished result is
  // published on the edge into DONE so sum/c_out are valid while done is high.
  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          carry_d = bus.sub ? ~bus.c_in : bus.c_in;
          err_d   = invalid;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      RUN: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (cnt_q == CNT_W'(i)) res_d[4*i +: 4] = cell_s;
        end
        carry_d = cell_cout;
        if (last) begin
          cnt_d   = '0;
          sum_d   = res_d;
          c_out_d = sub_q ? ~cell_cout : cell_cout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs: handshake decoded from state, results straight from their registers.
  always_comb begin
    ready     = (state_q == IDLE);
    bus.ready = ready;
    bus.done  = (state_q == DONE);
    bus.sum   = sum_q;
    bus.c_out = c_out_q;
    bus.err   = err_q;
  end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Directed bench for bcd_addsub_serial: a 4-digit and a 1-digit instance share clock and reset.
module tb_bcd_addsub_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  bcd_addsub_serial_if #(.DIGITS(4)) bus4 ();
  bcd_addsub_serial_if #(.DIGITS(1)) bus1 ();

  bcd_addsub_serial #(.DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  bcd_addsub_serial #(.DIGITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Issue one op on the 4-digit unit; lat = negedges after the accept edge until done.
  task automatic run_op4(input logic s, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, output int lat, output bit rdy_low);
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.sub   = s;
    bus4.a     = av;
    bus4.b     = bv;
    bus4.c_in  = ci;
    @(negedge clk);
    bus4.start = 1'b0;
    lat     = 0;
    rdy_low = 1'b1;
    while (bus4.done !== 1'b1 && lat < 30) begin
      if (bus4.ready !== 1'b0) rdy_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bus4.ready !== 1'b0) rdy_low = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++; if (bus4.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 1", bus4.ready); end
    vectors++; if (bus4.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", bus4.done); end
    vectors++; if (bus4.sum !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_sum: got %h expected 0000", bus4.sum); end
    vectors++; if (bus4.c_out !== 1'b0 || bus4.err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_flags: got c_out=%b err=%b expected 0 0", bus4.c_out, bus4.err); end
    vectors++; if (bus1.ready !== 1'b1 || bus1.sum !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_d1: got ready=%b sum=%h expected 1 0", bus1.ready, bus1.sum); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat; bit rl;
    run_op4(1'b0, 16'h1234, 16'h5678, 1'b0, lat, rl);
    vectors++; if (lat !== 4) begin miscompares++; $display("[TB] FAIL add_latency: got %0d expected 4", lat); end
    vectors++; if (rl !== 1'b1) begin miscompares++; $display("[TB] FAIL add_ready_low: got %b expected 1", rl); end
    vectors++; if (bus4.sum !== 16'h6912) begin miscompares++; $display("[TB] FAIL add_sum: got %h expected 6912", bus4.sum); end
    vectors++; if (bus4.c_out !== 1'b0) begin miscompares++; $display("[TB] FAIL add_cout: got %b expected 0", bus4.c_out); end
    @(negedge clk);
    vectors++; if (bus4.done !== 1'b0 || bus4.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL add_pulse: got done=%b ready=%b expected 0 1", bus4.done, bus4.ready); end
    @(negedge clk);
    vectors++; if (bus4.sum !== 16'h6912) begin miscompares++; $display("[TB] FAIL add_hold: got %h expected 6912", bus4.sum); end
  endtask

  task automatic test_add_wrap();
    int lat; bit rl;
    run_op4(1'b0, 16'h9999, 16'h0001, 1'b0, lat, rl);
    vectors++; if (bus4.sum !== 16'h0000 || bus4.c_out !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_9999p1: got %h c=%b expected 0000 c=1", bus4.sum, bus4.c_out); end
    run_op4(1'b0, 16'h0000, 16'h0000, 1'b1, lat, rl);
    vectors++; if (bus4.sum !== 16'h0001 || bus4.c_out !== 1'b0) begin miscompares++; $display("[TB] FAIL add_cin: got %h c=%b expected 0001 c=0", bus4.sum, bus4.c_out); end
  endtask

  task automatic test_sub();
    int lat; bit rl;
    run_op4(1'b1, 16'h5000, 16'h1234, 1'b0, lat, rl);
    vectors++; if (bus4.sum !== 16'h3766 || bus4.c_out !== 1'b0) begin miscompares++; $display("[TB] FAIL sub_5000: got %h c=%b expected 3766 c=0", bus4.sum, bus4.c_out); end
    run_op4(1'b1, 16'h0123, 16'h0456, 1'b0, lat, rl);
    vectors++; if (bus4.sum !== 16'h9667 || bus4.c_out !== 1'b1) begin miscompares++; $display("[TB] FAIL sub_borrow: got %h c=%b expected 9667 c=1", bus4.sum, bus4.c_out); end
    vectors++; if (lat !== 4) begin miscompares++; $display("[TB] FAIL sub_latency: got %0d expected 4", lat); end
    run_op4(1'b1, 16'h1000, 16'h0999, 1'b1, lat, rl);
    vectors++; if (bus4.sum !== 16'h0000 || bus4.c_out !== 1'b0) begin miscompares++; $display("[TB] FAIL sub_bin: got %h c=%b expected 0000 c=0", bus4.sum, bus4.c_out); end
  endtask

  task automatic test_err_ignore();
    int lat; bit rl; int pulses;
    @(negedge clk);
    bus4.start = 1'b1; bus4.sub = 1'b0; bus4.a = 16'h00A0; bus4.b = 16'h0000; bus4.c_in = 1'b0;
    @(negedge clk);
    bus4.start = 1'b0;
    vectors++; if (bus4.err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_set: got %b expected 1", bus4.err); end
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 16'h1111;
    @(negedge clk);
    bus4.start = 1'b0;
    pulses = 0;
    repeat (10) begin
      if (bus4.done === 1'b1) pulses++;
      @(negedge clk);
    end
    vectors++; if (pulses !== 1) begin miscompares++; $display("[TB] FAIL run_start_ignored: got %0d done pulses expected 1", pulses); end
    vectors++; if (bus4.err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_hold: got %b expected 1", bus4.err); end
    run_op4(1'b0, 16'h0001, 16'h0002, 1'b0, lat, rl);
    vectors++; if (bus4.err !== 1'b0 || bus4.sum !== 16'h0003) begin miscompares++; $display("[TB] FAIL err_clear: got err=%b sum=%h expected 0 0003", bus4.err, bus4.sum); end
  endtask

  task automatic test_reset_mid_run();
    int lat; bit rl; int pulses;
    @(negedge clk);
    bus4.start = 1'b1; bus4.sub = 1'b0; bus4.a = 16'h12F4; bus4.b = 16'h5678; bus4.c_in = 1'b0;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    vectors++; if (bus4.err !== 1'b1 || bus4.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL pre_reset: got err=%b ready=%b expected 1 0", bus4.err, bus4.ready); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (bus4.ready !== 1'b1 || bus4.done !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_hs: got ready=%b done=%b expected 1 0", bus4.ready, bus4.done); end
    vectors++; if (bus4.sum !== 16'h0000 || bus4.c_out !== 1'b0 || bus4.err !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_out: got sum=%h c=%b err=%b expected 0000 0 0", bus4.sum, bus4.c_out, bus4.err); end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus4.done === 1'b1) pulses++;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("[TB] FAIL midreset_nodone: got %0d pulses expected 0", pulses); end
    run_op4(1'b0, 16'h1234, 16'h5678, 1'b0, lat, rl);
    vectors++; if (bus4.sum !== 16'h6912 || lat !== 4) begin miscompares++; $display("[TB] FAIL after_reset: got sum=%h lat=%0d expected 6912 4", bus4.sum, lat); end
  endtask

  task automatic test_digits1();
    int lat;
    @(negedge clk);
    bus1.start = 1'b1; bus1.sub = 1'b0; bus1.a = 4'h7; bus1.b = 4'h5; bus1.c_in = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    lat = 0;
    while (bus1.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    vectors++; if (lat !== 1) begin miscompares++; $display("[TB] FAIL d1_latency: got %0d expected 1", lat); end
    vectors++; if (bus1.sum !== 4'h3 || bus1.c_out !== 1'b1) begin miscompares++; $display("[TB] FAIL d1_sum: got %h c=%b expected 3 c=1", bus1.sum, bus1.c_out); end
  endtask

  task automatic test_back_to_back();
    int pulses; int last_idx;
    @(negedge clk);
    bus1.start = 1'b1; bus1.sub = 1'b0; bus1.a = 4'h7; bus1.b = 4'h5; bus1.c_in = 1'b1;
    pulses = 0;
    last_idx = 0;
    for (int idx = 1; idx <= 12; idx++) begin
      @(negedge clk);
      if (bus1.done === 1'b1) begin
        if (pulses > 0) begin
          vectors++; if (idx - last_idx !== 3) begin miscompares++; $display("[TB] FAIL b2b_gap: got %0d cycles expected 3", idx - last_idx); end
        end
        vectors++; if (bus1.sum !== 4'h3) begin miscompares++; $display("[TB] FAIL b2b_sum: got %h expected 3", bus1.sum); end
        pulses++;
        last_idx = idx;
      end
    end
    bus1.start = 1'b0;
    vectors++; if (pulses !== 4) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d pulses expected 4", pulses); end
  endtask

  // Runaway guard in case a handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    bus4.start = 1'b0; bus4.sub = 1'b0; bus4.a = '0; bus4.b = '0; bus4.c_in = 1'b0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0;
    test_reset();
    test_add();
    test_add_wrap();
    test_sub();
    test_err_ignore();
    test_reset_mid_run();
    test_digits1();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
